// File: rtl/exec_datapath_if.sv
// Core-side bundle for the execution datapath: register-file ports, decode fields and ALU operands/result.
// The control FSM holds the master end; exec_datapath holds the slave end.
interface exec_datapath_if;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  w;
  logic [31:0] data_in;
  logic        we;
  logic [31:0] data_out1;
  logic [31:0] data_out2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [3:0]  fmt;
  logic [3:0]  alu_ctr;
  logic [31:0] ALU_srcA;
  logic [31:0] ALU_srcB;
  logic [31:0] ALU_resp;
  logic        zero;

  modport master (
    output rs1, rs2, w, data_in, we, funct3, funct7, fmt, ALU_srcA, ALU_srcB,
    input  data_out1, data_out2, alu_ctr, ALU_resp, zero
  );

  modport slave (
    input  rs1, rs2, w, data_in, we, funct3, funct7, fmt, ALU_srcA, ALU_srcB,
    output data_out1, data_out2, alu_ctr, ALU_resp, zero
  );
endinterface

// File: rtl/exec_datapath.sv
// RV32I integer datapath: 32x32 register file (async read, no bypass), ALU-control decoder and registered ALU.
// Reads and decode are combinational; ALU_resp/zero follow the operands by one clock. No flow control.
module exec_datapath (
  input  logic         clk,
  input  logic         reset,
  exec_datapath_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_SLT   = 4'd3,
    OP_SLTU  = 4'd4,
    OP_XOR   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_OR    = 4'd8,
    OP_AND   = 4'd9,
    OP_PASSA = 4'd10,
    OP_ADDJ  = 4'd11
  } alu_op_t;

  typedef enum logic [3:0] {
    FMT_R  = 4'd0,
    FMT_I  = 4'd1,
    FMT_IL = 4'd2,
    FMT_IE = 4'd3,
    FMT_S  = 4'd4,
    FMT_B  = 4'd5,
    FMT_J  = 4'd6,
    FMT_JI = 4'd7,
    FMT_U  = 4'd8,
    FMT_UP = 4'd9
  } fmt_t;

  // ---------------- register file ----------------
  // x0 has no storage; its reads are forced to zero below.
  logic [31:0] regs [1:31];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.we && (bus.w != 5'd0)) begin
      regs[bus.w] <= bus.data_in;
    end
  end

  assign bus.data_out1 = (bus.rs1 == 5'd0) ? 32'd0 : regs[bus.rs1];
  assign bus.data_out2 = (bus.rs2 == 5'd0) ? 32'd0 : regs[bus.rs2];

  // ---------------- ALU-control decoder ----------------
  alu_op_t op;
  logic    alt;

  assign alt = bus.funct7[5];

  always_comb begin
    op = OP_ADD;
    case (bus.fmt)
      FMT_R, FMT_I: begin
        case (bus.funct3)
          3'd0:    op = ((bus.fmt == FMT_R) && alt) ? OP_SUB : OP_ADD;
          3'd1:    op = OP_SLL;
          3'd2:    op = OP_SLT;
          3'd3:    op = OP_SLTU;
          3'd4:    op = OP_XOR;
          3'd5:    op = alt ? OP_SRA : OP_SRL;
          3'd6:    op = OP_OR;
          default: op = OP_AND;
        endcase
      end
      FMT_JI:  op = OP_ADDJ;
      FMT_U:   op = OP_PASSA;
      default: op = OP_ADD;
    endcase
  end

  assign bus.alu_ctr = op;

  logic unused_funct7;
  assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

  // ---------------- ALU ----------------
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic [31:0] sum;
  logic [31:0] alu_y;

  assign a     = bus.ALU_srcA;
  assign b     = bus.ALU_srcB;
  assign shamt = b[4:0];
  assign sum   = a + b;

  always_comb begin
    alu_y = '0;
    case (op)
      OP_ADD:   alu_y = sum;
      OP_SUB:   alu_y = a - b;
      OP_SLL:   alu_y = a << shamt;
      OP_SLT:   alu_y = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU:  alu_y = {31'd0, a < b};
      OP_XOR:   alu_y = a ^ b;
      OP_SRL:   alu_y = a >> shamt;
      OP_SRA:   alu_y = $signed(a) >>> shamt;
      OP_OR:    alu_y = a | b;
      OP_AND:   alu_y = a & b;
      OP_PASSA: alu_y = a;
      OP_ADDJ:  alu_y = sum & ~32'd1;
      default:  alu_y = '0;
    endcase
  end

  logic [31:0] resp_q;
  logic        zero_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_q <= '0;
      zero_q <= 1'b1;
    end else begin
      resp_q <= alu_y;
      zero_q <= (alu_y == 32'd0);
    end
  end

  assign bus.ALU_resp = resp_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_exec_datapath.sv
// Scoreboard bench for exec_datapath: expected ALU results are queued as operands are driven
// and popped one edge later; register-file checks use a local shadow array.
module tb_exec_datapath;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exec_datapath_if bus ();

  exec_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  fmt;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctr;
    logic [31:0] res;
  } op_t;

  typedef struct {
    logic [31:0] resp;
    logic        zero;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic op_t mk(input logic [3:0] fmt, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] ctr, input logic [31:0] res);
    op_t o;
    o.fmt = fmt; o.f3 = f3; o.f7 = f7; o.a = a; o.b = b; o.ctr = ctr; o.res = res;
    return o;
  endfunction

  // Independent reference for R-format behaviour (ctr and result).
  function automatic logic [35:0] ref_r(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [3:0]  c;
    r = '0;
    c = '0;
    case (f3)
      3'd0: begin c = alt ? 4'd1 : 4'd0; r = alt ? a - b : a + b; end
      3'd1: begin c = 4'd2; r = a << b[4:0]; end
      3'd2: begin c = 4'd3; r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
      3'd3: begin c = 4'd4; r = (a < b) ? 32'd1 : 32'd0; end
      3'd4: begin c = 4'd5; r = a ^ b; end
      3'd5: begin
        if (alt) begin c = 4'd7; r = $signed(a) >>> b[4:0]; end
        else     begin c = 4'd6; r = a >> b[4:0]; end
      end
      3'd6: begin c = 4'd8; r = a | b; end
      default: begin c = 4'd9; r = a & b; end
    endcase
    return {c, r};
  endfunction

  task automatic apply_op(input op_t o, input string tag);
    exp_t e;
    bus.fmt      = o.fmt;
    bus.funct3   = o.f3;
    bus.funct7   = o.f7;
    bus.ALU_srcA = o.a;
    bus.ALU_srcB = o.b;
    e.resp = o.res;
    e.zero = (o.res == 32'd0);
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    bus.we = 1'b1; bus.w = 5'd8; bus.data_in = 32'h1111_2222;
    bus.fmt = 4'd0; bus.funct3 = 3'd0; bus.funct7 = 7'd0;
    bus.ALU_srcA = 32'd1; bus.ALU_srcB = 32'd2;
    tick();
    tick();
    for (int i = 0; i < 32; i += 8) begin
      bus.rs1 = 5'(i);
      bus.rs2 = 5'(i + 7);
      #1;
      n_cmp++;
      if (bus.data_out1 !== 32'd0) begin
        n_bad++; $display("FAIL reset_rd1 x%0d: got %h want 0", i, bus.data_out1);
      end
      n_cmp++;
      if (bus.data_out2 !== 32'd0) begin
        n_bad++; $display("FAIL reset_rd2 x%0d: got %h want 0", i + 7, bus.data_out2);
      end
    end
    n_cmp++;
    if (bus.ALU_resp !== 32'd0) begin
      n_bad++; $display("FAIL reset_resp: got %h want 0", bus.ALU_resp);
    end
    n_cmp++;
    if (bus.zero !== 1'b1) begin
      n_bad++; $display("FAIL reset_zero: got %b want 1", bus.zero);
    end
    reset = 1'b0;
    bus.ALU_srcA = 32'd0; bus.ALU_srcB = 32'd0;
    bus.w = 5'd0; bus.data_in = 32'hDEAD_BEEF; bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
    bus.rs1 = 5'd0; bus.rs2 = 5'd8;
    #1;
    n_cmp++;
    if (bus.data_out1 !== 32'd0) begin
      n_bad++; $display("FAIL x0_write: got %h want 0", bus.data_out1);
    end
    n_cmp++;
    if (bus.data_out2 !== 32'd0) begin
      n_bad++; $display("FAIL reset_beats_we x8: got %h want 0", bus.data_out2);
    end
    // Reset in the middle of an operation discards the pending result.
    apply_op(mk(4'd0, 3'd4, 7'd0, 32'hF0F0_0000, 32'h0000_0F0F, 4'd5, 32'hF0F0_0F0F), "pre_reset");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (bus.ALU_resp !== 32'd0 || bus.zero !== 1'b1) begin
      n_bad++; $display("FAIL midop_reset: got %h/%b want 0/1 (discarded %s)", bus.ALU_resp, bus.zero, e.tag);
    end
  endtask

  task automatic test_regfile();
    logic [31:0] shadow [32];
    bus.w = 5'd5; bus.data_in = 32'h1234_5678; bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
    bus.rs1 = 5'd5; bus.rs2 = 5'd5;
    #1;
    n_cmp++;
    if (bus.data_out1 !== 32'h1234_5678) begin
      n_bad++; $display("FAIL wr_x5_rd1: got %h want 12345678", bus.data_out1);
    end
    n_cmp++;
    if (bus.data_out2 !== 32'h1234_5678) begin
      n_bad++; $display("FAIL wr_x5_rd2: got %h want 12345678", bus.data_out2);
    end
    bus.data_in = 32'hAAAA_5555; bus.we = 1'b1;
    #1;
    n_cmp++;
    if (bus.data_out1 !== 32'h1234_5678) begin
      n_bad++; $display("FAIL rdw_before_edge: got %h want 12345678", bus.data_out1);
    end
    tick();
    bus.we = 1'b0;
    n_cmp++;
    if (bus.data_out2 !== 32'hAAAA_5555) begin
      n_bad++; $display("FAIL rdw_after_edge: got %h want aaaa5555", bus.data_out2);
    end
    shadow[0] = 32'd0;
    for (int i = 0; i < 32; i++) begin
      bus.w = 5'(i); bus.data_in = $urandom; bus.we = 1'b1;
      if (i != 0) shadow[i] = bus.data_in;
      tick();
    end
    bus.we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.rs1 = 5'(i); bus.rs2 = 5'(31 - i);
      #1;
      n_cmp++;
      if (bus.data_out1 !== shadow[i] || bus.data_out2 !== shadow[31 - i]) begin
        n_bad++;
        $display("FAIL rf_sweep x%0d/x%0d: got %h/%h want %h/%h", i, 31 - i,
                 bus.data_out1, bus.data_out2, shadow[i], shadow[31 - i]);
      end
    end
  endtask

  task automatic test_r_decode();
    op_t  tbl[$];
    exp_t e;
    tbl.push_back(mk(4'd0, 3'd0, 7'h20, 32'd5, 32'd7, 4'd1, 32'hFFFF_FFFE));
    tbl.push_back(mk(4'd0, 3'd0, 7'h20, 32'd9, 32'd9, 4'd1, 32'd0));
    tbl.push_back(mk(4'd0, 3'd0, 7'h00, 32'd5, 32'd7, 4'd0, 32'd12));
    tbl.push_back(mk(4'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0));
    tbl.push_back(mk(4'd0, 3'd1, 7'h00, 32'd1, 32'h24, 4'd2, 32'h10));
    tbl.push_back(mk(4'd0, 3'd4, 7'h00, 32'hF0F0, 32'h0FF0, 4'd5, 32'hFF00));
    tbl.push_back(mk(4'd0, 3'd6, 7'h00, 32'hF0, 32'h0F, 4'd8, 32'hFF));
    tbl.push_back(mk(4'd0, 3'd7, 7'h00, 32'hF0F0, 32'hFF00, 4'd9, 32'hF000));
    foreach (tbl[i]) begin
      apply_op(tbl[i], $sformatf("r_decode[%0d]", i));
      #1;
      n_cmp++;
      if (bus.alu_ctr !== tbl[i].ctr) begin
        n_bad++; $display("FAIL r_decode[%0d] alu_ctr: got %0d want %0d", i, bus.alu_ctr, tbl[i].ctr);
      end
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.ALU_resp !== e.resp) begin
        n_bad++; $display("FAIL %s resp: got %h want %h", e.tag, bus.ALU_resp, e.resp);
      end
      n_cmp++;
      if (bus.zero !== e.zero) begin
        n_bad++; $display("FAIL %s zero: got %b want %b", e.tag, bus.zero, e.zero);
      end
    end
  endtask

  task automatic test_shifts();
    op_t  tbl[$];
    exp_t e;
    tbl.push_back(mk(4'd0, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 4'd7, 32'hF800_0000));
    tbl.push_back(mk(4'd0, 3'd5, 7'h00, 32'h8000_0000, 32'd4, 4'd6, 32'h0800_0000));
    tbl.push_back(mk(4'd0, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 4'd3, 32'd1));
    tbl.push_back(mk(4'd0, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd0));
    tbl.push_back(mk(4'd1, 3'd0, 7'h20, 32'd5, 32'd7, 4'd0, 32'd12));
    tbl.push_back(mk(4'd1, 3'd5, 7'h20, 32'h8000_0000, 32'h404, 4'd7, 32'hF800_0000));
    tbl.push_back(mk(4'd1, 3'd2, 7'h00, 32'd3, 32'hFFFF_FFFE, 4'd3, 32'd0));
    tbl.push_back(mk(4'd1, 3'd3, 7'h00, 32'd3, 32'hFFFF_FFFE, 4'd4, 32'd1));
    foreach (tbl[i]) begin
      apply_op(tbl[i], $sformatf("shift_cmp[%0d]", i));
      #1;
      n_cmp++;
      if (bus.alu_ctr !== tbl[i].ctr) begin
        n_bad++; $display("FAIL shift_cmp[%0d] alu_ctr: got %0d want %0d", i, bus.alu_ctr, tbl[i].ctr);
      end
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.ALU_resp !== e.resp || bus.zero !== e.zero) begin
        n_bad++; $display("FAIL %s: got %h/%b want %h/%b", e.tag, bus.ALU_resp, bus.zero, e.resp, e.zero);
      end
    end
  endtask

  task automatic test_formats();
    op_t  tbl[$];
    exp_t e;
    tbl.push_back(mk(4'd8,  3'd0, 7'h00, 32'h1234_5000, 32'd12, 4'd10, 32'h1234_5000));
    tbl.push_back(mk(4'd7,  3'd0, 7'h00, 32'h1001, 32'd4, 4'd11, 32'h1004));
    tbl.push_back(mk(4'd5,  3'd1, 7'h00, 32'h100, 32'hFFFF_FFF8, 4'd0, 32'hF8));
    tbl.push_back(mk(4'd9,  3'd0, 7'h00, 32'h1000, 32'h200, 4'd0, 32'h1200));
    tbl.push_back(mk(4'd2,  3'd4, 7'h20, 32'h10, 32'd4, 4'd0, 32'h14));
    tbl.push_back(mk(4'd4,  3'd5, 7'h20, 32'h20, 32'hFFFF_FFE0, 4'd0, 32'd0));
    tbl.push_back(mk(4'd6,  3'd0, 7'h20, 32'h1001, 32'd4, 4'd0, 32'h1005));
    tbl.push_back(mk(4'd3,  3'd1, 7'h00, 32'd3, 32'd4, 4'd0, 32'd7));
    tbl.push_back(mk(4'd12, 3'd7, 7'h00, 32'd6, 32'd1, 4'd0, 32'd7));
    tbl.push_back(mk(4'd15, 3'd0, 7'h20, 32'd6, 32'd6, 4'd0, 32'd12));
    foreach (tbl[i]) begin
      apply_op(tbl[i], $sformatf("fmt[%0d]", i));
      #1;
      n_cmp++;
      if (bus.alu_ctr !== tbl[i].ctr) begin
        n_bad++; $display("FAIL fmt[%0d] alu_ctr: got %0d want %0d", i, bus.alu_ctr, tbl[i].ctr);
      end
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.ALU_resp !== e.resp || bus.zero !== e.zero) begin
        n_bad++; $display("FAIL %s: got %h/%b want %h/%b", e.tag, bus.ALU_resp, bus.zero, e.resp, e.zero);
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t         o;
    exp_t        e;
    logic [35:0] r;
    for (int i = 0; i < 40; i++) begin
      o.fmt = 4'd0;
      o.f3  = 3'($urandom_range(0, 7));
      o.f7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      o.a   = (i % 5 == 0) ? 32'h8000_0000 | $urandom : $urandom;
      o.b   = (i % 7 == 0) ? o.a : $urandom;
      r     = ref_r(o.f3, o.f7[5], o.a, o.b);
      o.ctr = r[35:32];
      o.res = r[31:0];
      apply_op(o, $sformatf("b2b[%0d]", i));
      #1;
      n_cmp++;
      if (bus.alu_ctr !== o.ctr) begin
        n_bad++; $display("FAIL b2b[%0d] alu_ctr: got %0d want %0d", i, bus.alu_ctr, o.ctr);
      end
      tick();
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b2b[%0d]: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.ALU_resp !== e.resp || bus.zero !== e.zero) begin
          n_bad++; $display("FAIL %s: got %h/%b want %h/%b", e.tag, bus.ALU_resp, bus.zero, e.resp, e.zero);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.rs1 = '0; bus.rs2 = '0; bus.w = '0; bus.data_in = '0; bus.we = 1'b0;
    bus.funct3 = '0; bus.funct7 = '0; bus.fmt = '0;
    bus.ALU_srcA = '0; bus.ALU_srcB = '0;
    #2;
    test_reset();
    test_regfile();
    test_r_decode();
    test_shifts();
    test_formats();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_datapath.md
# exec_datapath

Integer execution datapath of the multicycle RV32I core: a 32×32 register file, an ALU-control decoder and a registered ALU in one block. The core's control FSM drives register addresses, write-back data, instruction fields, a format code and the two ALU operands. The block returns register read data, the decoded ALU operation, the ALU result one clock later, and a zero flag.

## Interface
- Parameters: none. Data width is fixed at 32 and register count at 32.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `rs1` input 5: read address, port 1.
- `rs2` input 5: read address, port 2.
- `w` input 5: write address.
- `data_in` input 32: write-back data.
- `we` input 1: register write enable.
- `data_out1` output 32: register read data, port 1 (`x[rs1]`).
- `data_out2` output 32: register read data, port 2 (`x[rs2]`).
- `funct3` input 3: instruction field [14:12].
- `funct7` input 7: instruction field [31:25].
- `fmt` input 4: format code. R=0, I=1, IL=2, IE=3, S=4, B=5, J=6, JI=7, U=8, UP=9.
- `alu_ctr` output 4: decoded ALU operation (combinational).
- `ALU_srcA` input 32: ALU operand A.
- `ALU_srcB` input 32: ALU operand B.
- `ALU_resp` output 32: registered ALU result.
- `zero` output 1: registered flag, high when `ALU_resp == 0`.

## Operation
- **Register file**
  - Holds 32 registers of 32 bits.
  - Reads are asynchronous and combinational.
  - Writes occur on the rising edge when `we=1` and `w!=0`.
  - `x0` always reads 0; writes to it are ignored.
- **ALU operation codes (`alu_ctr`)**
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 PASSA: result = A.
  - 11 ADDJ: result = (A+B) & ~1.
  - Codes 12–15 produce result 0.
- **Decoder, R format (`fmt`=0)**
  - funct3 0: SUB if `funct7[5]` is 1, otherwise ADD.
  - funct3 1 SLL, 2 SLT, 3 SLTU, 4 XOR.
  - funct3 5: SRA if `funct7[5]` is 1, otherwise SRL.
  - funct3 6 OR, 7 AND.
- **Decoder, I format (`fmt`=1)**
  - Same mapping as R format, except funct3 0 is always ADD.
  - SRAI/SRLI are still selected by `funct7[5]`.
- **Decoder, other formats**
  - IL, S, B, J, UP produce ADD.
  - JI produces ADDJ.
  - U produces PASSA.
  - IE and codes 10–15 produce ADD.
- **ALU arithmetic**
  - All arithmetic is 32-bit modulo 2^32.
  - Shift amount is `ALU_srcB[4:0]`.
  - SLT compares signed; SLTU compares unsigned.
  - Set results are 0 or 1.
  - SRA sign-extends.

## Timing
- The decoder is fully combinational.
- The ALU computes combinationally from the operands and `alu_ctr`. The result and zero flag are captured on the rising edge.
  - Operands presented in cycle N appear on `ALU_resp`/`zero` in cycle N+1.
  - The registered values hold until the next edge. The core changes operands in the following state without disturbing them until that edge.
- `ALU_resp` updates on every non-reset edge; there is no enable.
- **Reset** (synchronous, evaluated on the rising edge)
  - Clears all 32 registers to 0.
  - Sets `ALU_resp`=0 and `zero`=1.
  - Reset wins over a simultaneous `we`.
  - Reset mid-operation discards any in-flight result.
- **Read-during-write**
  - Before the edge, a read of `w` returns the old value.
  - After the edge it returns the new value.
  - There is no bypass.
- Both read ports may address the same register, or the register being written, in the same cycle.

## Test plan
1. **Reset and x0:** assert `reset` one edge → all reads 0, `ALU_resp`=0, `zero`=1. Then write `x0`=0xDEADBEEF with `we=1` → `data_out1` with `rs1`=0 reads 0.
2. **Write/read and read-during-write:** write `x5`=0x12345678 → after the edge `data_out1`/`data_out2` with `rs1`=`rs2`=5 read 0x12345678. In the cycle the write of 0xAAAA5555 is pending, reads still show 0x12345678.
3. **R decode and one-cycle latency:** `fmt`=0, funct3=0, `funct7`=0x20, A=5, B=7 → `alu_ctr`=1. Next cycle `ALU_resp`=0xFFFFFFFE and `zero`=0. With A=B=9 → `ALU_resp`=0 and `zero`=1.
4. **Shifts and compares:**
   - SRA: A=0x80000000, B=4 → 0xF8000000.
   - SRL: same operands → 0x08000000.
   - SLT: A=0xFFFFFFFF, B=1 → 1.
   - SLTU: same operands → 0.
   - I-format funct3=0 with `funct7`=0x20 → ADD.
5. **Format overrides:**
   - U: A=0x12345000, B=12 → 0x12345000.
   - JI: A=0x1001, B=4 → 0x1004.
   - B: A=0x100, B=0xFFFFFFF8 → 0xF8.
   - UP: A=0x1000, B=0x200 → 0x1200.
